// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite channel types, response codes and a byte-strobe merge helper.
package axi4l_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [STRB_W-1:0] strb_t;
   typedef logic [2:0]        prot_t;
   typedef logic [1:0]        resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   function automatic data_t merge_strb(input data_t old_d, input data_t new_d, input strb_t strb);
      data_t res;
      res = old_d;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = new_d[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle between the interconnect (master) and a register responder (slave).
interface axi4l_if
   import axi4l_pkg::*;
(
   input logic aclk,
   input logic aresetn
);

   addr_t awaddr;
   prot_t awprot;
   logic  awvalid;
   logic  awready;
   data_t wdata;
   strb_t wstrb;
   logic  wvalid;
   logic  wready;
   resp_t bresp;
   logic  bvalid;
   logic  bready;
   addr_t araddr;
   prot_t arprot;
   logic  arvalid;
   logic  arready;
   data_t rdata;
   resp_t rresp;
   logic  rvalid;
   logic  rready;

   modport master (
      input  aclk, aresetn,
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  aclk, aresetn,
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/axi4l_wr_join.sv
// Joins independently arriving AW and W beats into one write request; a beat that
// arrives alone is parked until its partner shows up.
module axi4l_wr_join
   import axi4l_pkg::*;
(
   input  logic  aclk,
   input  logic  areset,
   input  logic  i_block,
   input  logic  i_aw_valid,
   output logic  o_aw_ready,
   input  addr_t i_aw_addr,
   input  logic  i_w_valid,
   output logic  o_w_ready,
   input  data_t i_w_data,
   input  strb_t i_w_strb,
   output logic  o_req,
   output addr_t o_req_addr,
   output data_t o_req_data,
   output strb_t o_req_strb,
   input  logic  i_ack
);

   logic  r_aw_held;
   logic  r_w_held;
   addr_t r_aw_addr;
   data_t r_w_data;
   strb_t r_w_strb;

   logic  w_aw_hs;
   logic  w_w_hs;

   assign o_aw_ready = !r_aw_held && !i_block;
   assign o_w_ready  = !r_w_held && !i_block;
   assign w_aw_hs    = i_aw_valid && o_aw_ready;
   assign w_w_hs     = i_w_valid && o_w_ready;

   // A live handshake counts as available in the same cycle, so AW+W together commit at once.
   assign o_req      = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign o_req_addr = r_aw_held ? r_aw_addr : i_aw_addr;
   assign o_req_data = r_w_held ? r_w_data : i_w_data;
   assign o_req_strb = r_w_held ? r_w_strb : i_w_strb;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_addr <= '0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
      end else if (o_req && i_ack) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_addr <= i_aw_addr;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_w_data <= i_w_data;
            r_w_strb <= i_w_strb;
         end
      end
   end

endmodule

// File: rtl/axi4l_regfile.sv
// AXI4-Lite register bank: NREGS 32-bit registers with byte-strobed writes, registered
// read data, per-register write pulses and hardware-sourced read-only entries.
module axi4l_regfile
   import axi4l_pkg::*;
#(
   parameter int                     NREGS     = 8,
   parameter logic [NREGS-1:0]       RO_MASK   = '0,
   parameter logic [NREGS-1:0][31:0] RESET_VAL = '0
)(
   input  logic                     aclk,
   input  logic                     areset,
   axi4l_if.slave                   axis,
   output logic [NREGS-1:0][31:0]   reg_q,
   input  logic [NREGS-1:0][31:0]   hw_d,
   output logic [NREGS-1:0]         wr_pulse
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [IDX_W:0] NREGS_L = NREGS[IDX_W:0];

   typedef logic [IDX_W-1:0] idx_t;

   function automatic logic in_range(input idx_t idx);
      return {1'b0, idx} < NREGS_L;
   endfunction

   function automatic logic writable(input idx_t idx);
      if (!in_range(idx)) return 1'b0;
      return !RO_MASK[idx];
   endfunction

   logic                     r_rdy_en;
   logic [NREGS-1:0][31:0]   r_regs;
   logic [NREGS-1:0]         r_wr_pulse;
   logic                     r_bvalid;
   resp_t                    r_bresp;
   logic                     r_rvalid;
   data_t                    r_rdata;
   resp_t                    r_rresp;

   logic  w_req;
   addr_t w_req_addr;
   data_t w_req_data;
   strb_t w_req_strb;
   idx_t  w_wr_idx;
   idx_t  w_rd_idx;
   logic  w_wr_ok;
   logic  w_rd_ok;
   logic  w_ar_hs;
   data_t w_rd_data;
   logic  w_unused;

   axi4l_wr_join u_wr_join (
      .aclk       (aclk),
      .areset     (areset),
      .i_block    (!r_rdy_en || r_bvalid),
      .i_aw_valid (axis.awvalid),
      .o_aw_ready (axis.awready),
      .i_aw_addr  (axis.awaddr),
      .i_w_valid  (axis.wvalid),
      .o_w_ready  (axis.wready),
      .i_w_data   (axis.wdata),
      .i_w_strb   (axis.wstrb),
      .o_req      (w_req),
      .o_req_addr (w_req_addr),
      .o_req_data (w_req_data),
      .o_req_strb (w_req_strb),
      .i_ack      (w_req)
   );

   // The interconnect already decoded the window, so only the word index bits matter here.
   assign w_wr_idx = w_req_addr[2 +: IDX_W];
   assign w_rd_idx = axis.araddr[2 +: IDX_W];
   assign w_wr_ok  = writable(w_wr_idx);
   assign w_ar_hs  = axis.arvalid && axis.arready;

   assign axis.arready = r_rdy_en && !r_rvalid;
   assign axis.bvalid  = r_bvalid;
   assign axis.bresp   = r_bresp;
   assign axis.rvalid  = r_rvalid;
   assign axis.rdata   = r_rdata;
   assign axis.rresp   = r_rresp;

   assign reg_q    = r_regs;
   assign wr_pulse = r_wr_pulse;

   assign w_unused = ^{axis.aclk, axis.aresetn, axis.awprot, axis.arprot,
                       w_req_addr, axis.araddr, hw_d};

   always_comb begin
      w_rd_data = '0;
      w_rd_ok   = in_range(w_rd_idx);
      if (w_rd_ok) w_rd_data = RO_MASK[w_rd_idx] ? hw_d[w_rd_idx] : r_regs[w_rd_idx];
   end

   // Holds the ready outputs low for the first cycle after reset is released.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_rdy_en <= 1'b0;
      else        r_rdy_en <= 1'b1;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= RO_MASK[i] ? 32'h0 : RESET_VAL[i];
         end
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_req && w_wr_ok) begin
            r_regs[w_wr_idx]     <= merge_strb(r_regs[w_wr_idx], w_req_data, w_req_strb);
            r_wr_pulse[w_wr_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_req) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && axis.bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read data is sampled from r_regs before any same-edge write lands.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && axis.rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4l_regfile.sv
// Self-checking bench for axi4l_regfile: directed scenarios plus randomized traffic
// compared against an array-based model of the register bank.
module tb_axi4l_regfile;
   import axi4l_pkg::*;

   localparam int N = 6;
   localparam logic [N-1:0] RO = 6'b101000;
   localparam logic [N-1:0][31:0] RV = {32'hA5A5_0005, 32'hA5A5_0004, 32'hA5A5_0003,
                                        32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

   logic aclk = 1'b0;
   logic areset = 1'b0;
   logic aresetn;
   logic [N-1:0][31:0] reg_q;
   logic [N-1:0][31:0] hw_d;
   logic [N-1:0]       wr_pulse;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] m_regs [N];

   always #5 aclk = ~aclk;
   assign aresetn = ~areset;

   axi4l_if axis_if (.aclk(aclk), .aresetn(aresetn));

   axi4l_regfile #(.NREGS(N), .RO_MASK(RO), .RESET_VAL(RV)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .axis     (axis_if),
      .reg_q    (reg_q),
      .hw_d     (hw_d),
      .wr_pulse (wr_pulse)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 2) & 32'h7);
   endfunction

   function automatic bit m_writable(input int idx);
      return (idx < N) && !RO[idx];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_regs[i] = RO[i] ? 32'h0 : RV[i];
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < N; i++) check($sformatf("%s reg_q[%0d]", tag, i), reg_q[i], m_regs[i]);
   endtask

   task automatic m_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
      int idx;
      idx = m_idx(addr);
      if (idx >= N) begin
         d = 32'h0;
         r = RESP_SLVERR;
      end else begin
         d = RO[idx] ? hw_d[idx] : m_regs[idx];
         r = RESP_OKAY;
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_d, input int w_d, input int bp);
      logic [1:0]   exp_resp;
      logic [N-1:0] exp_pulse;
      int idx, c;
      bit aw_done, w_done, aw_hs, w_hs;
      idx = m_idx(addr);
      if (m_writable(idx)) begin
         exp_resp  = RESP_OKAY;
         exp_pulse = N'(1) << idx;
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
         exp_resp  = RESP_SLVERR;
         exp_pulse = '0;
      end
      aw_done = 0;
      w_done  = 0;
      c = 0;
      while (!(aw_done && w_done) && c < 40) begin
         @(negedge aclk);
         if (w_done && !aw_done) check("wready_after_w", 32'(axis_if.wready), 32'd0);
         if (aw_done && !w_done) check("awready_after_aw", 32'(axis_if.awready), 32'd0);
         axis_if.awaddr  = addr;
         axis_if.wdata   = data;
         axis_if.wstrb   = strb;
         axis_if.awvalid = !aw_done && (c >= aw_d);
         axis_if.wvalid  = !w_done && (c >= w_d);
         aw_hs = axis_if.awvalid && axis_if.awready;
         w_hs  = axis_if.wvalid && axis_if.wready;
         @(posedge aclk);
         aw_done = aw_done | aw_hs;
         w_done  = w_done | w_hs;
         c++;
      end
      check("wr_accept_cycles", 32'(c), 32'(((aw_d > w_d) ? aw_d : w_d) + 1));
      @(negedge aclk);
      axis_if.awvalid = 1'b0;
      axis_if.wvalid  = 1'b0;
      check("bvalid", 32'(axis_if.bvalid), 32'd1);
      check("bresp", 32'(axis_if.bresp), 32'(exp_resp));
      check("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
      check_regs("after_write");
      for (int k = 0; k < bp; k++) begin
         @(negedge aclk);
         check("bvalid_hold", 32'(axis_if.bvalid), 32'd1);
         check("bresp_hold", 32'(axis_if.bresp), 32'(exp_resp));
         check("awready_bp", 32'(axis_if.awready), 32'd0);
         check("wready_bp", 32'(axis_if.wready), 32'd0);
         check("wr_pulse_1cyc", 32'(wr_pulse), 32'd0);
      end
      axis_if.bready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      axis_if.bready = 1'b0;
      check("bvalid_clear", 32'(axis_if.bvalid), 32'd0);
      check("awready_back", 32'(axis_if.awready), 32'd1);
      check("wready_back", 32'(axis_if.wready), 32'd1);
      if (bp == 0) check("wr_pulse_1cyc", 32'(wr_pulse), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int rp);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      int c;
      m_read(addr, exp_d, exp_r);
      @(negedge aclk);
      axis_if.araddr  = addr;
      axis_if.arvalid = 1'b1;
      c = 0;
      while (!axis_if.arready && c < 20) begin
         @(negedge aclk);
         c++;
      end
      check("ar_wait", 32'(c), 32'd0);
      @(posedge aclk);
      @(negedge aclk);
      axis_if.arvalid = 1'b0;
      check("rvalid", 32'(axis_if.rvalid), 32'd1);
      check("rdata", axis_if.rdata, exp_d);
      check("rresp", 32'(axis_if.rresp), 32'(exp_r));
      for (int k = 0; k < rp; k++) begin
         @(negedge aclk);
         check("rvalid_hold", 32'(axis_if.rvalid), 32'd1);
         check("rdata_hold", axis_if.rdata, exp_d);
         check("arready_bp", 32'(axis_if.arready), 32'd0);
      end
      axis_if.rready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      axis_if.rready = 1'b0;
      check("rvalid_clear", 32'(axis_if.rvalid), 32'd0);
      check("arready_back", 32'(axis_if.arready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr, pre;
      int idx;
      axis_if.awaddr = '0;  axis_if.awprot = '0; axis_if.awvalid = 1'b0;
      axis_if.wdata  = '0;  axis_if.wstrb  = '0; axis_if.wvalid  = 1'b0;
      axis_if.bready = 1'b0;
      axis_if.araddr = '0;  axis_if.arprot = '0; axis_if.arvalid = 1'b0;
      axis_if.rready = 1'b0;
      hw_d = '0;
      hw_d[3] = 32'hCAFE_0001;
      hw_d[5] = 32'h5A5A_1234;
      m_reset();

      #1 areset = 1'b1;
      #20;
      check("rst_awready", 32'(axis_if.awready), 32'd0);
      check("rst_wready", 32'(axis_if.wready), 32'd0);
      check("rst_arready", 32'(axis_if.arready), 32'd0);
      check("rst_bvalid", 32'(axis_if.bvalid), 32'd0);
      check("rst_rvalid", 32'(axis_if.rvalid), 32'd0);
      check("rst_rdata", axis_if.rdata, 32'd0);
      check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      check_regs("reset");
      @(negedge aclk);
      areset = 1'b0;
      #1 check("awready_release", 32'(axis_if.awready), 32'd0);
      @(negedge aclk);
      check("awready_rise", 32'(axis_if.awready), 32'd1);
      check("wready_rise", 32'(axis_if.wready), 32'd1);
      check("arready_rise", 32'(axis_if.arready), 32'd1);

      // Ordering of AW vs W: W early, AW early, and both together.
      do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
      check("w_first_val", reg_q[1], 32'hDEAD_BEEF);
      do_write(32'h4, 32'h1234_5678, 4'hF, 0, 2, 0);
      do_write(32'h4, 32'h8765_4321, 4'hF, 0, 0, 0);

      do_write(32'h8, 32'h1122_3344, 4'hF, 0, 0, 0);
      do_write(32'h8, 32'hAABB_CCDD, 4'b0101, 1, 0, 0);
      check("strb_merge", reg_q[2], 32'h11BB_33DD);
      do_read(32'h8, 0);
      do_write(32'h4, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);

      do_write(32'h18, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
      do_read(32'h1C, 0);
      do_write(32'hC, 32'h7777_7777, 4'hF, 0, 1, 0);
      do_read(32'hC, 0);
      check("ro_read_val", axis_if.rdata, 32'hCAFE_0001);

      do_write(32'h10, 32'h0F0F_0F0F, 4'hF, 0, 0, 5);
      do_read(32'h10, 5);

      // Read and joined write hit register 0 at the same edge.
      do_write(32'h0, 32'd5, 4'hF, 0, 0, 0);
      pre = m_regs[0];
      @(negedge aclk);
      axis_if.awaddr = 32'h0; axis_if.wdata = 32'd9; axis_if.wstrb = 4'hF;
      axis_if.araddr = 32'h0;
      axis_if.awvalid = 1'b1; axis_if.wvalid = 1'b1; axis_if.arvalid = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      axis_if.awvalid = 1'b0; axis_if.wvalid = 1'b0; axis_if.arvalid = 1'b0;
      m_regs[0] = 32'd9;
      check("coll_rvalid", 32'(axis_if.rvalid), 32'd1);
      check("coll_rdata", axis_if.rdata, pre);
      check("coll_bvalid", 32'(axis_if.bvalid), 32'd1);
      check("coll_reg0", reg_q[0], 32'd9);
      axis_if.bready = 1'b1; axis_if.rready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      axis_if.bready = 1'b0; axis_if.rready = 1'b0;

      for (int it = 0; it < 60; it++) begin
         idx  = $urandom_range(0, 7);
         addr = ($urandom() & 32'hFFFF_FFE0) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
         hw_d[5] = $urandom();
         if ($urandom_range(0, 1) == 1)
            do_write(addr, $urandom(), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else
            do_read(addr, $urandom_range(0, 2));
      end

      // Reset arriving with AW parked and W still outstanding.
      @(negedge aclk);
      axis_if.awaddr = 32'h4; axis_if.awvalid = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      axis_if.awvalid = 1'b0;
      check("parked_awready", 32'(axis_if.awready), 32'd0);
      check("parked_wready", 32'(axis_if.wready), 32'd1);
      #2 areset = 1'b1;
      #1;
      m_reset();
      check("mid_rst_awready", 32'(axis_if.awready), 32'd0);
      check("mid_rst_wready", 32'(axis_if.wready), 32'd0);
      check("mid_rst_arready", 32'(axis_if.arready), 32'd0);
      check_regs("mid_reset");
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      #1 check("rerel_awready", 32'(axis_if.awready), 32'd0);
      @(negedge aclk);
      check("rerel_bvalid", 32'(axis_if.bvalid), 32'd0);
      check("rerel_awready_up", 32'(axis_if.awready), 32'd1);
      check("rerel_wready_up", 32'(axis_if.wready), 32'd1);
      do_write(32'h4, 32'h0BAD_F00D, 4'hF, 1, 0, 0);
      do_read(32'h4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
